// File: rtl/addsub_pkg.sv
// Shared definitions for the add/sub accumulator: op encodings, NZCV bit positions, datapath width.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package addsub_pkg;

  localparam int WIDTH = 32;

  typedef enum logic [1:0] {
    OP_LOAD  = 2'b00,
    OP_ADD   = 2'b01,
    OP_SUB   = 2'b10,
    OP_CLEAR = 2'b11
  } op_e;

  // Bit positions inside the {N,Z,C,V} flag nibble
  localparam int FLAG_V = 0;
  localparam int FLAG_C = 1;
  localparam int FLAG_Z = 2;
  localparam int FLAG_N = 3;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_e;

endpackage

// File: rtl/addsub32.sv
// 32-bit ripple-carry adder/subtractor: ans = a + b (sub=0) or a - b (sub=1), with carry-out and signed overflow.
// Latency: purely combinational.
// Backpressure: none; no handshake at this level.
module addsub32 (
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic        sub_i,
  output logic [31:0] ans_o,
  output logic        cout_o,
  output logic        v_o
);

  logic [31:0] b_eff;
  logic        carry;

  // Subtraction is a + ~b + 1: invert B and inject the +1 as carry-in
  assign b_eff = b_i ^ {32{sub_i}};

  // Bit-serial carry chain, LSB first
  always_comb begin
    ans_o = '0;
    carry = sub_i;
    for (int i = 0; i < 32; i++) begin
      ans_o[i] = a_i[i] ^ b_eff[i] ^ carry;
      carry    = (a_i[i] & b_eff[i]) | (carry & (a_i[i] ^ b_eff[i]));
    end
    cout_o = carry;
  end

  // Overflow when both effective operands share a sign that the result does not
  assign v_o = (a_i[31] == b_eff[31]) && (ans_o[31] != a_i[31]);

endmodule

// File: rtl/addsub_accum.sv
// Accumulator stage: applies LOAD/ADD/SUB/CLEAR to a running ACC and registers result, NZCV and sticky overflow.
// Latency: 1 cycle from accept to out_valid; 1 op/cycle sustained with out_ready high.
// Backpressure: in_ready = !out_valid | out_ready; a held result stays stable. Optional ADDSUB_ACCUM_SAT_EN clamps on overflow.
module addsub_accum
  import addsub_pkg::*;
#(
  parameter int WIDTH = addsub_pkg::WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_acc,
  output logic [3:0]       out_flags,
  output logic             sticky_v,
  input  logic             clr_sticky
);

  state_e           state_q;
  logic             out_valid_q;
  logic [WIDTH-1:0] acc_q;
  logic [3:0]       flags_q;
  logic             sticky_q;

  logic             accept;
  op_e              op;
  logic             is_sub;
  logic [WIDTH-1:0] ans;
  logic             cout;
  logic             ovf;
  logic [WIDTH-1:0] res_d;
  logic [3:0]       flags_d;

  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;
  assign op       = op_e'(in_op);
  assign is_sub   = (op == OP_SUB);

  // ACC is always the A operand; the result register doubles as the accumulator
  addsub32 u_addsub (
    .a_i   (acc_q),
    .b_i   (in_data),
    .sub_i (is_sub),
    .ans_o (ans),
    .cout_o(cout),
    .v_o   (ovf)
  );

  // Select the op result and derive NZCV; N/Z always follow the value actually stored
  always_comb begin
    res_d   = '0;
    flags_d = '0;
    case (op)
      OP_LOAD: begin
        res_d = in_data;
      end
      OP_ADD, OP_SUB: begin
        res_d           = ans;
        flags_d[FLAG_C] = cout;
        flags_d[FLAG_V] = ovf;
      end
      default: begin
        res_d = '0;
      end
    endcase
`ifdef ADDSUB_ACCUM_SAT_EN
    // Clamp towards the sign of the running value; V still reports the overflow
    if (flags_d[FLAG_V]) begin
      res_d = acc_q[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
`endif
    flags_d[FLAG_N] = res_d[WIDTH-1];
    flags_d[FLAG_Z] = (res_d == '0);
  end

  // EMPTY/FULL handshake FSM plus result, flag and sticky registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_EMPTY;
      out_valid_q <= 1'b0;
      acc_q       <= '0;
      flags_q     <= '0;
      sticky_q    <= 1'b0;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            state_q     <= ST_FULL;
            out_valid_q <= 1'b1;
          end
        end
        ST_FULL: begin
          if (out_ready && !accept) begin
            state_q     <= ST_EMPTY;
            out_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q     <= ST_EMPTY;
          out_valid_q <= 1'b0;
        end
      endcase

      // Operands are only looked at on accept, so idle X never reaches ACC
      if (accept) begin
        acc_q   <= res_d;
        flags_q <= flags_d;
      end

      // Clear has priority over a same-cycle overflow
      if (clr_sticky) begin
        sticky_q <= 1'b0;
      end else if (accept && flags_d[FLAG_V]) begin
        sticky_q <= 1'b1;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_acc   = acc_q;
  assign out_flags = flags_q;
  assign sticky_v  = sticky_q;

endmodule

// File: tb/tb_addsub_accum.sv
// Directed bench for addsub_accum: driver pushes expected results into a queue, a monitor pops on each handshake.
// Latency: checks out_valid one cycle after every accept.
// Backpressure: exercises stalls, streaming and reset while FULL; honours ADDSUB_ACCUM_SAT_EN.
module tb_addsub_accum;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_op;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_acc;
  logic [3:0]  out_flags;
  logic        sticky_v;
  logic        clr_sticky;

  typedef struct {
    logic [31:0] acc;
    logic [3:0]  flags;
    logic        sticky;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  localparam logic [1:0] LD = 2'b00, AD = 2'b01, SB = 2'b10, CL = 2'b11;

`ifdef ADDSUB_ACCUM_SAT_EN
  localparam logic [31:0] OVP_ACC = 32'h7FFF_FFFF;
  localparam logic [3:0]  OVP_F   = 4'b0001;
  localparam logic [31:0] OVN_ACC = 32'h8000_0000;
  localparam logic [3:0]  OVN_F   = 4'b1011;
`else
  localparam logic [31:0] OVP_ACC = 32'h8000_0000;
  localparam logic [3:0]  OVP_F   = 4'b1001;
  localparam logic [31:0] OVN_ACC = 32'h7FFF_FFFF;
  localparam logic [3:0]  OVN_F   = 4'b0011;
`endif

  addsub_accum dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_acc   (out_acc),
    .out_flags (out_flags),
    .sticky_v  (sticky_v),
    .clr_sticky(clr_sticky)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compare every presented-and-consumed result against the queue head
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_output", out_acc, 32'hDEAD_BEEF);
        end else begin
          e = sb.pop_front();
          chk("acc", out_acc, e.acc);
          chk("flags", {28'd0, out_flags}, {28'd0, e.flags});
          chk("sticky", {31'd0, sticky_v}, {31'd0, e.sticky});
        end
      end
    end
  end

  task automatic issue(input logic [1:0] op, input logic [31:0] d, input logic [31:0] ea,
                       input logic [3:0] ef, input logic es, input logic clr);
    exp_t e;
    int   n;
    in_valid   = 1'b1;
    in_op      = op;
    in_data    = d;
    clr_sticky = clr;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 20) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) begin
      chk("issue_timeout", {31'd0, in_ready}, 32'd1);
    end else begin
      e.acc = ea; e.flags = ef; e.sticky = es;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    in_valid   = 1'b0;
    in_op      = 'x;
    in_data    = 'x;
    clr_sticky = 1'b0;
    chk("latency_out_valid", {31'd0, out_valid}, 32'd1);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_op = 'x; in_data = 'x;
    out_ready = 1'b1; clr_sticky = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_acc", out_acc, 32'd0);
    chk("rst_flags", {28'd0, out_flags}, 32'd0);
    chk("rst_sticky", {31'd0, sticky_v}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

    // Simple load / add
    issue(LD, 32'h0000_0021, 32'h0000_0021, 4'b0000, 1'b0, 1'b0);
    issue(AD, 32'h0000_0022, 32'h0000_0043, 4'b0000, 1'b0, 1'b0);

    // Signed overflow on add, sticky set
    issue(LD, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 4'b0000, 1'b0, 1'b0);
    issue(AD, 32'h0000_0001, OVP_ACC, OVP_F, 1'b1, 1'b0);

    // Subtract to zero, then a negative overflow with same-cycle clear
    issue(LD, 32'h336F_B7E5, 32'h336F_B7E5, 4'b0000, 1'b1, 1'b0);
    issue(SB, 32'h336F_B7E5, 32'h0000_0000, 4'b0110, 1'b1, 1'b0);
    issue(LD, 32'h8000_0000, 32'h8000_0000, 4'b1000, 1'b1, 1'b0);
    issue(SB, 32'h0000_0001, OVN_ACC, OVN_F, 1'b0, 1'b1);
    issue(CL, 32'h1234_5678, 32'h0000_0000, 4'b0100, 1'b0, 1'b0);

    // Backpressure: three stalled cycles with a pending request
    idle(2);
    out_ready = 1'b0;
    issue(LD, 32'h0000_0005, 32'h0000_0005, 4'b0000, 1'b0, 1'b0);
    fork
      issue(AD, 32'h0000_0003, 32'h0000_0008, 4'b0000, 1'b0, 1'b0);
      begin
        repeat (3) begin
          @(negedge clk);
          chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
          chk("bp_out_acc", out_acc, 32'h0000_0005);
          chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
        end
        @(posedge clk);
        #2 out_ready = 1'b1;
      end
    join

    // Streaming back-to-back through the wrap point
    idle(2);
    issue(LD, 32'hFFFF_FFFE, 32'hFFFF_FFFE, 4'b1000, 1'b0, 1'b0);
    issue(AD, 32'h0000_0001, 32'hFFFF_FFFF, 4'b1000, 1'b0, 1'b0);
    issue(AD, 32'h0000_0001, 32'h0000_0000, 4'b0110, 1'b0, 1'b0);
    issue(AD, 32'h0000_0001, 32'h0000_0001, 4'b0000, 1'b0, 1'b0);
    issue(AD, 32'h0000_0001, 32'h0000_0002, 4'b0000, 1'b0, 1'b0);

    // Reset while FULL with a pending request
    idle(2);
    issue(LD, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 4'b0000, 1'b0, 1'b0);
    issue(AD, 32'h0000_0001, OVP_ACC, OVP_F, 1'b1, 1'b0);
    out_ready = 1'b0;
    void'(sb.pop_back());
    @(negedge clk);
    chk("pre_rst_sticky", {31'd0, sticky_v}, 32'd1);
    chk("pre_rst_acc", out_acc, OVP_ACC);
    in_valid = 1'b1; in_op = AD; in_data = 32'h0000_0001; rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0; in_valid = 1'b0; in_op = 'x; in_data = 'x;
    chk("post_rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("post_rst_acc", out_acc, 32'd0);
    chk("post_rst_sticky", {31'd0, sticky_v}, 32'd0);
    out_ready = 1'b1;
    issue(AD, 32'h0000_0007, 32'h0000_0007, 4'b0000, 1'b0, 1'b0);

    idle(3);
    chk("scoreboard_empty", sb.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
